st_align_buf: RTL and testbench

ST_ALIGN_BUF -- requirements
Module: st_align_buf

---
 rtl/st_pkg.sv | 21 ++
 rtl/st_align.sv | 43 ++++
 rtl/st_align_buf.sv | 123 ++++++++++++
 tb/tb_st_align_buf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/st_pkg.sv
// Shared types and constants for the store alignment buffer.
package st_pkg;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  localparam int unsigned DefaultDepth = 2;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  web;
  } st_entry_t;

  // Active-low byte-enable for a single byte lane.
  function automatic logic [3:0] sb_web(input logic [1:0] lane);
    return ~(4'b0001 << lane);
  endfunction

endpackage

// File: rtl/st_align.sv
// Combinational store lane alignment: replicates data across lanes, builds the
// active-low byte enable and flags misaligned or unsupported stores.
module st_align
  import st_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output st_entry_t   entry_o,
  output logic        err_o
);

  always_comb begin
    entry_o.waddr = addr_i[31:2];
    entry_o.wdata = '0;
    entry_o.web   = 4'hF;
    err_o         = 1'b0;
    case (func3_i)
      SB: begin
        entry_o.wdata = {4{data_i[7:0]}};
        entry_o.web   = sb_web(addr_i[1:0]);
      end
      SH: begin
        if (addr_i[0]) begin
          err_o = 1'b1;
        end else begin
          entry_o.wdata = {2{data_i[15:0]}};
          entry_o.web   = addr_i[1] ? 4'b0011 : 4'b1100;
        end
      end
      SW: begin
        if (addr_i[1:0] != 2'b00) begin
          err_o = 1'b1;
        end else begin
          entry_o.wdata = data_i;
          entry_o.web   = 4'b0000;
        end
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/st_align_buf.sv
// Store buffer: aligns CPU stores and queues them FIFO toward data memory.
// Optional load-overlap hazard detection is enabled by defining ST_FWD_EN.
module st_align_buf
  import st_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  func3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_web,
  input  logic        mem_ack,
  output logic        st_err,
  output logic        empty,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  st_entry_t             mem_q [DEPTH];
  st_entry_t             new_entry;
  st_entry_t             head;
  logic                  new_err;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  st_err_q, st_err_d;
  logic                  full;
  logic                  accept;
  logic                  push;
  logic                  pop;

  st_align u_align (
    .func3_i (func3),
    .addr_i  (st_addr),
    .data_i  (st_data),
    .entry_o (new_entry),
    .err_o   (new_err)
  );

  assign full     = (count_q == CntFull);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !new_err;
  assign pop      = mem_req && mem_ack;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    st_err_d = accept && new_err;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_req   = !empty;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_web   = 4'hF;
    if (!empty) begin
      mem_addr  = {head.waddr, 2'b00};
      mem_wdata = head.wdata;
      mem_web   = head.web;
    end
  end

  assign st_err = st_err_q;

`ifdef ST_FWD_EN
  always_comb begin
    logic [PtrW-1:0] offs;
    ld_hazard = 1'b0;
    offs      = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offs = PtrW'(i) - rd_ptr_q;
      if ((CntW'(offs) < count_q) && (mem_q[i].waddr == ld_addr[31:2])) ld_hazard = 1'b1;
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hazard      = 1'b0;
`endif

endmodule

// File: tb/tb_st_align_buf.sv
// Directed self-checking bench for st_align_buf (DEPTH = 2).
module tb_st_align_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_web;
  logic        mem_ack;
  logic        st_err;
  logic        empty;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  int checks = 0;
  int errors = 0;
  logic exp_hz;

  st_align_buf #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func3     (func3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_web   (mem_web),
    .mem_ack   (mem_ack),
    .st_err    (st_err),
    .empty     (empty),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    in_valid = v;
    func3    = f;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] w);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_web"}, 32'(mem_web), 32'(w));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_web"}, 32'(mem_web), 32'hF);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    ld_addr = 32'h0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #3;
    chk_idle("rst");
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_err", 32'(st_err), 32'd0);
    chk("rst_hz", 32'(ld_hazard), 32'd0);
    #9 rst_n = 1'b1;

    // sb at 0x1003: lane 3, one-edge latency
    drive(1'b1, 3'b000, 32'h1003, 32'h0000_00AB);
    #1;
    chk("sb_pre_req", 32'(mem_req), 32'd0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk_head("sb", 32'h1000, 32'hABAB_ABAB, 4'b0111);
    chk("sb_empty", 32'(empty), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_idle("sb_pop");

    // ack with nothing pending is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_idle("idle_ack");

    // sh at 0x2002: upper half
    drive(1'b1, 3'b001, 32'h2002, 32'h0000_1234);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk_head("sh", 32'h2000, 32'h1234_1234, 4'b0011);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // misaligned sw, misaligned sh, illegal func3
    drive(1'b1, 3'b010, 32'h2001, 32'h5555_5555);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("sw_mis_err", 32'(st_err), 32'd1);
    chk("sw_mis_empty", 32'(empty), 32'd1);
    tick();
    chk("sw_mis_err_end", 32'(st_err), 32'd0);
    drive(1'b1, 3'b001, 32'h2001, 32'h0000_1234);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("sh_mis_err", 32'(st_err), 32'd1);
    chk("sh_mis_empty", 32'(empty), 32'd1);
    drive(1'b1, 3'b011, 32'h2000, 32'h0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("f3_err", 32'(st_err), 32'd1);
    chk("f3_empty", 32'(empty), 32'd1);
    tick();

    // three back-to-back stores with ack held low
    drive(1'b1, 3'b010, 32'h4000, 32'h1111_1111);
    tick();
    drive(1'b1, 3'b000, 32'h4005, 32'h0000_0022);
    tick();
    chk("full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, 3'b001, 32'h4008, 32'h0000_3333);
    tick();
    chk("full_rdy_hold", 32'(in_ready), 32'd0);
    chk_head("full_head", 32'h4000, 32'h1111_1111, 4'b0000);
    mem_ack = 1'b1;
    #1;
    chk("ack_no_comb_rdy", 32'(in_ready), 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("after_pop_rdy", 32'(in_ready), 32'd1);
    chk_head("second", 32'h4004, 32'h2222_2222, 4'b1101);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("third_in_rdy", 32'(in_ready), 32'd0);
    chk_head("second_keep", 32'h4004, 32'h2222_2222, 4'b1101);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_head("third", 32'h4008, 32'h3333_3333, 4'b1100);
    chk("third_rdy", 32'(in_ready), 32'd1);

    // push and pop together at count 1
    drive(1'b1, 3'b010, 32'h5000, 32'hDEAD_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk_head("pushpop", 32'h5000, 32'hDEAD_BEEF, 4'b0000);
    chk("pushpop_rdy", 32'(in_ready), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_idle("pushpop_drain");

    // async reset with two entries pending
    drive(1'b1, 3'b010, 32'h6000, 32'hAAAA_0000);
    tick();
    drive(1'b1, 3'b010, 32'h6004, 32'hBBBB_0000);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_addr", mem_addr, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk_idle("post_rst");

    // load hazard detection
`ifdef ST_FWD_EN
    exp_hz = 1'b1;
`else
    exp_hz = 1'b0;
`endif
    drive(1'b1, 3'b010, 32'h3004, 32'h0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    ld_addr = 32'h3007;
    #1;
    chk("hz_hit", 32'(ld_hazard), 32'(exp_hz));
    ld_addr = 32'h3008;
    #1;
    chk("hz_miss", 32'(ld_hazard), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    ld_addr = 32'h3004;
    #1;
    chk("hz_after_pop", 32'(ld_hazard), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
